fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Program-sequencing controller for the instruction ROM. Owns the program counter, starts execution on a start request, and steps or redirects the PC each cycle under branch and stall control from the core. It also detects the halt instruction and reports completion to the testbench/top level. It sits between the top-level handshake (Start/Done) and the combinational InstROM, whose address it drives and whose output it forwards to decode.

## Interface
Parameters:
- A, 10, PC / ROM address width
- W, 9, instruction width
- HALT, {W{1'b1}}, machine-code value of the halt instruction
- CW, 16, executed-instruction counter width

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clk
- Start  in  1  level; begin program at address 0 (honoured in IDLE and HALTED only)
- Stall  in  1  hold PC and counter this cycle
- BranchAbs  in  1  next PC = Target
- BranchRel  in  1  next PC = PC + Target (Target two's complement)
- Target  in  A  branch target / signed offset
- RomInst  in  W  instruction from InstROM at address PC (combinational, same cycle)
- PC  out  A  ROM address, registered
- Inst  out  W  instruction to decode = RomInst
- InstValid  out  1  high when Inst is an executing instruction
- Done  out  1  program halted, registered
- InstCount  out  CW  instructions retired since last start, registered

## Operation
- States: IDLE, RUN, HALTED.
- Reset: state=IDLE, PC=0, Done=0, InstCount=0. Inst follows RomInst unconditionally, so it is not a reset value. InstValid=0 as a result of state=IDLE.
- IDLE: PC held at 0. Start=1 -> RUN.
- RUN: InstValid=1. Per cycle, with priority top-down:
  - Stall=1: PC and InstCount hold. Halt is not taken; branches are ignored.
  - RomInst==HALT: -> HALTED. Done<=1. PC holds at the halt address. InstCount +1 (halt counts as retired). Branch inputs are ignored.
  - BranchAbs=1: PC<=Target. Takes priority over BranchRel if both are asserted.
  - BranchRel=1: PC<=PC+Target, computed mod 2^A. Wrap is silent.
  - Otherwise: PC<=PC+1. PC=2^A-1 wraps to 0.
  - Each non-stalled cycle: InstCount +1, saturating at 2^CW-1.
- HALTED: InstValid=0, Done=1, PC and InstCount frozen. Start=1 -> RUN, PC<=0, Done<=0, InstCount<=0.
- Start in RUN is ignored.
- Reset overrides everything in any state, including RUN mid-program and a simultaneous Start.

## Timing
- ROM is combinational: RomInst for address PC is valid in the same cycle. Fetch-to-decode latency is 0 cycles; the PC update takes effect at the next edge.
- Start sampled at edge n in IDLE: state=RUN and InstValid=1 from cycle n+1, executing address 0.
- Halt fetched at edge n: Done=1 and InstValid=0 from cycle n+1. Done stays high until Start or Reset.
- Branch decided in cycle n: the target instruction is executing in cycle n+1. There are no delay slots and no bubbles.
- Stall affects only the cycle in which it is asserted. Throughput is one instruction per non-stalled cycle.

## Structure
- Package fetch_pkg: state enum (IDLE, RUN, HALTED) and the default HALT constant.
- Single module with no sub-module. InstROM is instantiated beside fetch_ctrl at the top level, PC->InstROM.PC, InstROM.inst->RomInst.
- Next-PC logic goes in one always_comb; state, PC, Done and InstCount go in one always_ff.

## Test plan
- Reset then Start: ROM 0:ADD, 1:ADD, 2:HALT. Required: PC 0,1,2. Done rises one cycle after PC=2. InstCount=3. PC stays 2.
- BranchRel at PC=5 with Target=-3 -> next PC=2. BranchAbs at PC=2 with Target=8 -> next PC=8. Both asserted with Target=4 at PC=6 -> next PC=4 (absolute wins).
- Wrap: PC=1023 with no branch -> next PC=0. BranchRel at PC=1020 with Target=+10 -> next PC=6.
- Stall held for 3 cycles at PC=4 while RomInst=HALT: PC stays 4, InstCount unchanged, Done=0. Releasing Stall -> Done=1 next cycle.
- Reset asserted mid-RUN at PC=7 -> next cycle state=IDLE, PC=0, Done=0, InstValid=0. Start and Reset asserted together -> stays IDLE.
- Restart from HALTED: Start=1 -> PC=0, Done=0, InstCount=0, InstValid=1 next cycle. Start pulsed during RUN -> no effect on PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// No logic; nothing here is clocked.
// No backpressure; type and constant definitions only.
package fetch_pkg;

    // Controller phases: waiting for first start, executing, stopped on halt.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Default machine-code halt for the standard 9-bit instruction word.
    localparam int unsigned DEF_W    = 9;
    localparam logic [DEF_W-1:0] DEF_HALT = {DEF_W{1'b1}};

endpackage

// File: rtl/fetch_ctrl.sv
// Program counter sequencer for the combinational instruction ROM: start, step, branch, halt.
// Fetch-to-decode is 0 cycles (Inst = RomInst); PC/Done/InstCount update on the next edge.
// Stall holds PC and the retired count for that cycle only; Start is ignored while running.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned A    = 10,
    parameter int unsigned W    = 9,
    parameter logic [W-1:0] HALT = {W{1'b1}},
    parameter int unsigned CW   = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          BranchAbs,
    input  logic          BranchRel,
    input  logic [A-1:0]  Target,
    input  logic [W-1:0]  RomInst,
    output logic [A-1:0]  PC,
    output logic [W-1:0]  Inst,
    output logic          InstValid,
    output logic          Done,
    output logic [CW-1:0] InstCount
);

    state_t        state, state_nx;
    logic [A-1:0]  pc_nx;
    logic          done_nx;
    logic [CW-1:0] cnt_nx;
    logic          is_halt;

    // The ROM is combinational, so the current instruction goes straight to decode.
    assign Inst      = RomInst;
    assign InstValid = (state == RUN);
    assign is_halt   = (RomInst == HALT);

    // Next state, next PC and retired-count update; priority is stall, halt, abs, rel, step.
    always_comb begin
        state_nx = state;
        pc_nx    = PC;
        done_nx  = Done;
        cnt_nx   = InstCount;
        case (state)
            IDLE: begin
                pc_nx = '0;
                if (Start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!Stall) begin
                    // Halt counts as retired; the count saturates rather than wrapping.
                    if (InstCount != {CW{1'b1}}) begin
                        cnt_nx = InstCount + CW'(1);
                    end
                    if (is_halt) begin
                        state_nx = HALTED;
                        done_nx  = 1'b1;
                    end else if (BranchAbs) begin
                        pc_nx = Target;
                    end else if (BranchRel) begin
                        // A-bit add: two's-complement offset, wraps silently.
                        pc_nx = PC + Target;
                    end else begin
                        pc_nx = PC + A'(1);
                    end
                end
            end
            HALTED: begin
                if (Start) begin
                    state_nx = RUN;
                    pc_nx    = '0;
                    done_nx  = 1'b0;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                pc_nx    = '0;
                done_nx  = 1'b0;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, PC, Done and count registers; synchronous reset wins over any Start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            PC        <= '0;
            Done      <= 1'b0;
            InstCount <= '0;
        end else begin
            state     <= state_nx;
            PC        <= pc_nx;
            Done      <= done_nx;
            InstCount <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed program scenarios plus randomized control, checked every cycle.
// Reference model tracks running/done/pc/count as plain integers from the sequencing rules.
// Inputs change 1ns after the rising edge; outputs compared on the falling edge.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int A  = 10;
    localparam int W  = 9;
    localparam int CW = 16;
    localparam logic [W-1:0] HALT_I = DEF_HALT;
    localparam logic [W-1:0] ADD_I  = 9'h001;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Stall = 1'b0;
    logic          BranchAbs = 1'b0;
    logic          BranchRel = 1'b0;
    logic [A-1:0]  Target = '0;
    logic [W-1:0]  RomInst;
    logic [A-1:0]  PC;
    logic [W-1:0]  Inst;
    logic          InstValid;
    logic          Done;
    logic [CW-1:0] InstCount;

    logic [W-1:0] rom [0:(1<<A)-1];

    int checks = 0;
    int errors = 0;
    bit ready  = 1'b0;

    // Reference model state
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_pc   = 0;
    int m_cnt  = 0;

    fetch_ctrl #(.A(A), .W(W), .HALT(HALT_I), .CW(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchAbs(BranchAbs), .BranchRel(BranchRel), .Target(Target),
        .RomInst(RomInst), .PC(PC), .Inst(Inst), .InstValid(InstValid),
        .Done(Done), .InstCount(InstCount)
    );

    assign RomInst = rom[PC];

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic fill_rom(input logic [W-1:0] v);
        for (int i = 0; i < (1<<A); i++) rom[i] = v;
    endtask

    // Behavioural reference: one instruction retired per non-stalled running cycle.
    always @(posedge Clk) begin
        if (Reset) begin
            m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (Start) begin
                m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
            end
        end else if (!Stall) begin
            if (m_cnt < (1<<CW) - 1) m_cnt = m_cnt + 1;
            if (rom[m_pc] == HALT_I) begin
                m_run = 0; m_done = 1;
            end else if (BranchAbs) begin
                m_pc = int'(Target);
            end else if (BranchRel) begin
                m_pc = (m_pc + int'(Target)) % (1<<A);
            end else begin
                m_pc = (m_pc + 1) % (1<<A);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge Clk) begin
        if (ready) begin
            chk("cyc_pc",        int'(PC),        m_pc);
            chk("cyc_instvalid", int'(InstValid), int'(m_run));
            chk("cyc_done",      int'(Done),      int'(m_done));
            chk("cyc_count",     int'(InstCount), m_cnt);
            chk("cyc_inst",      int'(Inst),      int'(rom[m_pc]));
        end
    end

    initial begin
        fill_rom(ADD_I);
        rom[2] = HALT_I;
        step();
        step();
        Reset = 1'b0;
        ready = 1'b1;
        chk("rst_pc", int'(PC), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_valid", int'(InstValid), 0);
        chk("rst_count", int'(InstCount), 0);

        // Straight-line program ending in halt at address 2
        Start = 1'b1; step(); Start = 1'b0;
        chk("t1_valid", int'(InstValid), 1);
        chk("t1_pc0", int'(PC), 0);
        step(); chk("t1_pc1", int'(PC), 1);
        step(); chk("t1_pc2", int'(PC), 2);
        chk("t1_done_early", int'(Done), 0);
        step();
        chk("t1_done", int'(Done), 1);
        chk("t1_valid_off", int'(InstValid), 0);
        chk("t1_count", int'(InstCount), 3);
        step(); chk("t1_pc_hold", int'(PC), 2);

        // Restart from HALTED, then branches
        rom[2] = ADD_I;
        Start = 1'b1; step(); Start = 1'b0;
        chk("rs_pc", int'(PC), 0);
        chk("rs_done", int'(Done), 0);
        chk("rs_count", int'(InstCount), 0);
        chk("rs_valid", int'(InstValid), 1);
        repeat (5) step();
        chk("br_pc5", int'(PC), 5);
        BranchRel = 1'b1; Target = 10'h3FD; step(); BranchRel = 1'b0;
        chk("br_rel_neg", int'(PC), 2);
        BranchAbs = 1'b1; Target = 10'd8; step();
        chk("br_abs", int'(PC), 8);
        Target = 10'd6; step();
        BranchRel = 1'b1; Target = 10'd4; step();
        BranchAbs = 1'b0; BranchRel = 1'b0;
        chk("br_both", int'(PC), 4);
        Start = 1'b1; step(); Start = 1'b0;
        chk("start_in_run", int'(PC), 5);

        // Stall on a halt instruction at PC=4
        BranchAbs = 1'b1; Target = 10'd4; step(); BranchAbs = 1'b0;
        rom[4] = HALT_I;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_pc", int'(PC), 4);
            chk("st_count", int'(InstCount), 11);
            chk("st_done", int'(Done), 0);
        end
        Stall = 1'b0; step();
        chk("st_release_done", int'(Done), 1);
        chk("st_release_count", int'(InstCount), 12);
        chk("st_release_pc", int'(PC), 4);

        // Wrap-around
        rom[4] = ADD_I;
        Start = 1'b1; step(); Start = 1'b0;
        BranchAbs = 1'b1; Target = 10'd1023; step(); BranchAbs = 1'b0;
        chk("wr_pc1023", int'(PC), 1023);
        step(); chk("wr_step", int'(PC), 0);
        BranchAbs = 1'b1; Target = 10'd1020; step(); BranchAbs = 1'b0;
        BranchRel = 1'b1; Target = 10'd10; step(); BranchRel = 1'b0;
        chk("wr_rel", int'(PC), 6);

        // Reset mid-run, then Reset together with Start
        BranchAbs = 1'b1; Target = 10'd7; step(); BranchAbs = 1'b0;
        chk("rm_pc7", int'(PC), 7);
        Reset = 1'b1; step();
        chk("rm_pc", int'(PC), 0);
        chk("rm_done", int'(Done), 0);
        chk("rm_valid", int'(InstValid), 0);
        Start = 1'b1; step();
        chk("rm_start_valid", int'(InstValid), 0);
        Reset = 1'b0; Start = 1'b0; step();
        chk("rm_idle_valid", int'(InstValid), 0);

        // Randomized control against the model
        for (int i = 0; i < (1<<A); i++)
            rom[i] = ($urandom_range(15) == 0) ? HALT_I : W'($urandom_range(510));
        for (int c = 0; c < 3000; c++) begin
            Reset     = ($urandom_range(199) == 0);
            Start     = ($urandom_range(5) == 0);
            Stall     = ($urandom_range(7) == 0);
            BranchAbs = ($urandom_range(9) == 0);
            BranchRel = ($urandom_range(9) == 0);
            Target    = A'($urandom_range((1<<A)-1));
            step();
        end

        // Counter saturation on a halt-free program
        Reset = 1'b1; Start = 1'b0; Stall = 1'b0; BranchAbs = 1'b0; BranchRel = 1'b0;
        fill_rom(ADD_I);
        step();
        Reset = 1'b0;
        Start = 1'b1; step(); Start = 1'b0;
        repeat (65540) @(posedge Clk);
        #1;
        chk("sat_count", int'(InstCount), 65535);
        chk("sat_valid", int'(InstValid), 1);

        ready = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
